// File: rtl/traffic_mode_arbiter.sv
// traffic_mode_arbiter: day/night/pedestrian/emergency mode controller with round-robin crosswalk service.
// Define TRAFFIC_EMG_COUNT_EN to add the saturating emergency-entry counter on emg_events.
module traffic_mode_arbiter #(
    parameter int PED_CH    = 4,
    parameter int PED_DWELL = 16,
    parameter int EMG_HOLD  = 8,
    parameter int CNT_W     = 8
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              night_sig,
    input  logic [PED_CH-1:0] ped_req,
    input  logic              emg_sig,
    output logic [1:0]        mode,
    output logic              mode_change,
    output logic [PED_CH-1:0] ped_grant,
    output logic [PED_CH-1:0] ped_pending
`ifdef TRAFFIC_EMG_COUNT_EN
    ,
    output logic [15:0]       emg_events
`endif
);
    localparam int PW = PED_CH > 1 ? $clog2(PED_CH) : 1;
    typedef enum logic [2:0] {S_NIGHT, S_DAY, S_PED, S_EMG, S_HOLD} state_t;
    state_t st, st_n, idle_st;
    logic [CNT_W-1:0] tmr, tmr_n;
    logic [PW-1:0] ptr, ptr_n, hi_idx, lo_idx, nxt_idx;
    logic hit_hi, serve;
    logic [PED_CH-1:0] req_all, grant_oh, grant_n, pend_n;
    logic [1:0] mode_n;
    assign req_all = ped_pending | ped_req;
    assign idle_st = night_sig ? S_NIGHT : S_DAY;
    // Round robin: lowest requester above the pointer, else lowest overall.
    always_comb begin
        hi_idx = '0;
        lo_idx = '0;
        hit_hi = 1'b0;
        for (int i = PED_CH - 1; i >= 0; i--)
            if (req_all[i]) begin
                lo_idx = PW'(i);
                if (i > int'(ptr)) begin
                    hi_idx = PW'(i);
                    hit_hi = 1'b1;
                end
            end
        nxt_idx  = hit_hi ? hi_idx : lo_idx;
        grant_oh = PED_CH'(1) << nxt_idx;
    end
    always_comb begin
        st_n    = st;
        tmr_n   = tmr;
        ptr_n   = ptr;
        grant_n = ped_grant;
        pend_n  = req_all;
        serve   = 1'b0;
        case (st)
            S_NIGHT, S_DAY:
                if (emg_sig) st_n = S_EMG;
                else if (|req_all) serve = 1'b1;
                else st_n = idle_st;
            S_PED:
                if (emg_sig) begin
                    st_n    = S_EMG;
                    grant_n = '0;
                    pend_n  = req_all | ped_grant;
                    tmr_n   = '0;
                end else if (tmr <= CNT_W'(1)) begin
                    if (|req_all) serve = 1'b1;
                    else begin
                        st_n    = idle_st;
                        grant_n = '0;
                    end
                end else tmr_n = tmr - CNT_W'(1);
            S_EMG:
                if (!emg_sig) begin
                    if (EMG_HOLD > 0) begin
                        st_n  = S_HOLD;
                        tmr_n = CNT_W'(EMG_HOLD);
                    end else if (|req_all) serve = 1'b1;
                    else st_n = idle_st;
                end
            S_HOLD:
                if (emg_sig) st_n = S_EMG;
                else if (tmr <= CNT_W'(1)) begin
                    if (|req_all) serve = 1'b1;
                    else st_n = idle_st;
                end else tmr_n = tmr - CNT_W'(1);
            default: st_n = S_DAY;
        endcase
        // A grant clears its own pending bit even if the request is still high.
        if (serve) begin
            st_n    = S_PED;
            grant_n = grant_oh;
            ptr_n   = nxt_idx;
            tmr_n   = CNT_W'(PED_DWELL);
            pend_n  = req_all & ~grant_oh;
        end
        mode_n = st_n == S_NIGHT ? 2'b00 : st_n == S_DAY ? 2'b01 : st_n == S_PED ? 2'b10 : 2'b11;
    end
    always_ff @(posedge clk or negedge rst_n)
        if (!rst_n) begin
            st          <= S_DAY;
            tmr         <= '0;
            ptr         <= PW'(PED_CH - 1);
            ped_grant   <= '0;
            ped_pending <= '0;
            mode        <= 2'b01;
            mode_change <= 1'b0;
        end else begin
            st          <= st_n;
            tmr         <= tmr_n;
            ptr         <= ptr_n;
            ped_grant   <= grant_n;
            ped_pending <= pend_n;
            mode        <= mode_n;
            mode_change <= mode_n != mode;
        end
`ifdef TRAFFIC_EMG_COUNT_EN
    always_ff @(posedge clk or negedge rst_n)
        if (!rst_n) emg_events <= '0;
        else if (st_n == S_EMG && st != S_EMG && st != S_HOLD && emg_events != 16'hFFFF)
            emg_events <= emg_events + 16'd1;
`endif
endmodule
